// File: rtl/seq_mult_taint.sv
// seq_mult_taint: sequential shift-and-add multiplier, one multiplier bit per
// cycle, with optional taint (information-flow) tracking.
// Optional feature macro: SEQ_MULT_TAINT_TRACK_EN builds the taint registers;
// without it every _t output is tied low and every _t input is ignored.
//
// Handshake: start is sampled only while idle (busy=0). The accept edge
// captures the operands; busy then stays high for WIDTH RUN cycles plus one
// DONE cycle, in which done pulses and product presents the result. product
// and product_t hold until the next completion.
module seq_mult_taint #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 start_t,
    input  logic                 signed_mode,
    input  logic                 signed_mode_t,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 multiplier_t,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 multiplicand_t,
    output logic                 busy,
    output logic                 busy_t,
    output logic                 done,
    output logic                 done_t,
    output logic [2*WIDTH-1:0]   product,
    output logic                 product_t
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [AW-1:0]        acc_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     mcand_q;
    logic                 smode_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 accept;
    logic                 finish;
    logic                 leave_done;
    logic [WIDTH:0]       mcand_ext;
    logic [WIDTH:0]       upper_d;
    logic [AW-1:0]        acc_d;

    assign accept     = (state_q == S_IDLE) && start;
    assign finish     = (state_q == S_RUN) && (cnt_q == '0);
    assign leave_done = (state_q == S_DONE);

    // One iteration: conditional add/subtract into the upper half, then shift.
    // The last iteration in signed mode subtracts (weight of the MSB is negative).
    always_comb begin
        mcand_ext = smode_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
        upper_d   = acc_q[AW-1:WIDTH];
        if (mplier_q[0]) begin
            if (smode_q && (cnt_q == '0)) begin
                upper_d = acc_q[AW-1:WIDTH] - mcand_ext;
            end else begin
                upper_d = acc_q[AW-1:WIDTH] + mcand_ext;
            end
        end
        acc_d = {(smode_q ? upper_d[WIDTH] : 1'b0), upper_d, acc_q[WIDTH-1:1]};
    end

    // Control FSM with datapath registers and registered busy/done/product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            smode_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mplier_q <= multiplier;
                        mcand_q  <= multiplicand;
                        smode_q  <= signed_mode;
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH - 1);
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == '0) begin
                        product_q <= acc_d[2*WIDTH-1:0];
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

`ifdef SEQ_MULT_TAINT_TRACK_EN
    logic data_t_q;
    logic ctrl_t_q;
    logic product_t_q;

    // Taint state: data taint follows the operands into product; control taint
    // follows only start_t, since latency never depends on operand values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_t_q    <= 1'b0;
            ctrl_t_q    <= 1'b0;
            product_t_q <= 1'b0;
        end else begin
            if (accept) begin
                data_t_q <= multiplier_t | multiplicand_t | signed_mode_t | start_t;
                ctrl_t_q <= start_t;
            end else if (leave_done) begin
                ctrl_t_q <= 1'b0;
            end
            if (finish) begin
                product_t_q <= data_t_q;
            end
        end
    end

    assign busy_t    = ctrl_t_q;
    assign done_t    = ctrl_t_q & done_q;
    assign product_t = product_t_q;
`else
    logic unused_taint;
    assign unused_taint = ^{start_t, signed_mode_t, multiplier_t, multiplicand_t,
                            accept, finish, leave_done};
    assign busy_t    = 1'b0;
    assign done_t    = 1'b0;
    assign product_t = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mult_taint.sv
// tb_seq_mult_taint: directed checks of seq_mult_taint (WIDTH=8). Taint
// expectations follow SEQ_MULT_TAINT_TRACK_EN; with it undefined they are 0.
module tb_seq_mult_taint;

    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;
    localparam int EXP_W = PW + 2 + 32;

`ifdef SEQ_MULT_TAINT_TRACK_EN
    localparam logic TRK = 1'b1;
`else
    localparam logic TRK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, start_t, signed_mode, signed_mode_t;
    logic [WIDTH-1:0]  multiplier, multiplicand;
    logic              multiplier_t, multiplicand_t;
    logic              busy, busy_t, done, done_t;
    logic [PW-1:0]     product;
    logic              product_t;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    logic [PW-1:0]     last_p   = '0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [EXP_W-1:0]  mon_e;

    seq_mult_taint #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_t        (start_t),
        .signed_mode    (signed_mode),
        .signed_mode_t  (signed_mode_t),
        .multiplier     (multiplier),
        .multiplier_t   (multiplier_t),
        .multiplicand   (multiplicand),
        .multiplicand_t (multiplicand_t),
        .busy           (busy),
        .busy_t         (busy_t),
        .done           (done),
        .done_t         (done_t),
        .product        (product),
        .product_t      (product_t)
    );

    // Clock and cycle counter (cyc == n after the n-th rising edge).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("product",    64'(product),   64'(mon_e[EXP_W-1 -: PW]));
                check("product_t",  64'(product_t), 64'(mon_e[33]));
                check("done_t",     64'(done_t),    64'(mon_e[32]));
                check("busy_t_done",64'(busy_t),    64'(mon_e[32]));
                check("busy_done",  64'(busy),      64'(1));
                check("done_cycle", 64'(cyc),       64'(mon_e[31:0]));
            end
        end
    end

    task automatic push_exp(input logic [PW-1:0] p, input logic pt, input logic ct, input int dcyc);
        exp_q.push_back({p, pt, ct, 32'(dcyc)});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; start_t = 1'b0; signed_mode = 1'b0; signed_mode_t = 1'b0;
        multiplier_t = 1'b0; multiplicand_t = 1'b0;
    endtask

    // Driver: one single-cycle start request and its expected result.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sm, input logic a_t, input logic b_t,
                          input logic sm_t, input logic st_t, input logic [PW-1:0] exp_p);
        int   k;
        logic pt, ct;
        @(negedge clk);
        multiplier = a; multiplicand = b; signed_mode = sm;
        multiplier_t = a_t; multiplicand_t = b_t; signed_mode_t = sm_t;
        start_t = st_t; start = 1'b1;
        k  = cyc + 1;
        pt = TRK & (a_t | b_t | sm_t | st_t);
        ct = TRK & st_t;
        push_exp(exp_p, pt, ct, k + WIDTH);
        @(negedge clk);
        idle_inputs();
        check("busy_after_accept", 64'(busy), 64'(1));
        check("busy_t_run", 64'(busy_t), 64'(ct));
        check("product_held", 64'(product), 64'(last_p));
        last_p = exp_p;
        wait_drain();
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        multiplier = '0; multiplicand = '0;
        idle_inputs();
        #12;
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_done",      64'(done),      64'(0));
        check("rst_product",   64'(product),   64'(0));
        check("rst_product_t", 64'(product_t), 64'(0));
        check("rst_busy_t",    64'(busy_t),    64'(0));
        check("rst_done_t",    64'(done_t),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic vectors: a, b, signed, a_t, b_t, sm_t, start_t, expected.
        run_op(8'd13,  8'd11,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h008F);
        run_op(8'hFD,  8'h05,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFF1);
        run_op(8'h80,  8'h80,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000);
        run_op(8'hFF,  8'hFF,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFE01);
        run_op(8'h00,  8'h5A,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        run_op(8'h7F,  8'h80,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hC080);
        // Taint vectors.
        run_op(8'd6,   8'd7,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h002A);
        run_op(8'd3,   8'd4,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000C);
        run_op(8'd2,   8'd3,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0006);
        run_op(8'd9,   8'd9,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0051);

        // start held high: accepts every WIDTH+2 edges; start_t only while busy.
        @(negedge clk);
        multiplier = 8'd2; multiplicand = 8'd3; signed_mode = 1'b0; start = 1'b1;
        k = cyc + 1;
        push_exp(16'd6, 1'b0, 1'b0, k + WIDTH);
        push_exp(16'd6, 1'b0, 1'b0, k + WIDTH + 10);
        push_exp(16'd6, 1'b0, 1'b0, k + WIDTH + 20);
        for (int i = 0; i < 30; i++) begin
            start_t = ((i % 10) != 0);
            @(negedge clk);
        end
        idle_inputs();
        wait_drain();
        last_p = 16'd6;

        // Reset in the 4th RUN cycle aborts the operation with no done.
        @(negedge clk);
        multiplier = 8'd5; multiplicand = 8'd5; start = 1'b1; start_t = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",      64'(busy),      64'(0));
        check("abort_done",      64'(done),      64'(0));
        check("abort_product",   64'(product),   64'(0));
        check("abort_product_t", 64'(product_t), 64'(0));
        check("abort_busy_t",    64'(busy_t),    64'(0));
        check("abort_done_t",    64'(done_t),    64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_p = '0;
        run_op(8'd7, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd63);

        repeat (12) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
